// File: rtl/jesd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : jesd_pkg
// Description : Shared helpers for the JESD sample packer: a clog2 helper,
//               the per-sample byte-swap function and the packing order.
// Revision    : 1.0 - initial release
// ============================================================================
package jesd_pkg;

  // Widest beat the swap helper handles; callers zero-extend into it.
  localparam int MAX_BEAT_W = 512;

  // 1: the first beat of a word lands at the least significant slot.
  localparam bit PACK_LSB_FIRST = 1'b1;

  // Ceiling log2 for elaboration-time sizing (value 1 yields 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the byte order inside every sample_w-bit sample of the beat.
  function automatic logic [MAX_BEAT_W-1:0] swap_samples(
    input logic [MAX_BEAT_W-1:0] data,
    input int                    sample_w
  );
    logic [MAX_BEAT_W-1:0] r;
    int nb;
    int s;
    int b;
    r  = data;
    nb = sample_w / 8;
    for (int i = 0; i < MAX_BEAT_W / 8; i++) begin
      s = i / nb;
      b = i % nb;
      if ((s + 1) * nb <= MAX_BEAT_W / 8) begin
        r[i*8 +: 8] = data[(s*nb + nb - 1 - b)*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jesd_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jesd_fwft_fifo
// Description : First-word-fall-through FIFO with registered storage. The
//               head word is visible whenever the FIFO is non-empty. A push
//               while full is accepted only when a pop happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module jesd_fwft_fifo
  import jesd_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2(DEPTH):0]   o_level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  // Full/empty from pointers carrying one extra wrap bit.
  always_comb begin
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_do_pop  = i_pop && !w_empty;
    w_do_push = i_push && (!w_full || w_do_pop);
  end

  // Storage write; when full with a pop, the slot being freed is reused.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Head word is forced to zero while empty so stale storage never shows.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/jesd_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : jesd_sample_packer
// Description : Byte-swaps JESD sample beats, packs RATIO beats into one wide
//               word (first beat at LSB) and buffers words in a FWFT FIFO with
//               backpressure, overflow detection and on-demand realignment.
// Revision    : 1.0 - initial release
// ============================================================================
module jesd_sample_packer
  import jesd_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int SAMPLE_W   = 16,
  parameter bit SWAP_EN    = 1'b1,
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [IN_W-1:0]             s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        sync_restart,
  output logic [IN_W*RATIO-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        ovf_clear,
  output logic                        overflow,
  output logic [CNT_W-1:0]            drop_count,
  output logic [clog2(FIFO_DEPTH):0]  fill_level
);

  localparam int WORD_W = IN_W * RATIO;
  localparam int KW     = clog2(RATIO);

  logic [IN_W-1:0]   w_beat;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     w_k_eff;
  logic [KW-1:0]     w_slot;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word;
  logic              w_last;
  logic              r_push;
  logic [WORD_W-1:0] r_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_count;

  generate
    if (SWAP_EN) begin : g_swap
      // Reverse bytes inside each sample of the incoming beat.
      always_comb begin
        w_beat = IN_W'(swap_samples(MAX_BEAT_W'(s_axis_tdata), SAMPLE_W));
      end
    end else begin : g_pass
      // Beat passes through untouched.
      always_comb begin
        w_beat = s_axis_tdata;
      end
    end
  endgenerate

  // Merge the current beat into the partial word; a restart drops the partial.
  always_comb begin
    w_k_eff = sync_restart ? '0 : r_k;
    w_slot  = PACK_LSB_FIRST ? w_k_eff : (KW'(RATIO - 1) - w_k_eff);
    w_word  = sync_restart ? '0 : r_word;
    w_word[w_slot*IN_W +: IN_W] = w_beat;
    w_last  = s_axis_tvalid && (w_k_eff == KW'(RATIO - 1));
  end

  // Beat counter, partial word and registered push of each completed word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_k         <= '0;
      r_word      <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= w_last;
      if (w_last) r_push_data <= w_word;
      if (s_axis_tvalid) begin
        r_word <= w_last ? '0 : w_word;
        r_k    <= w_last ? '0 : (w_k_eff + KW'(1));
      end else if (sync_restart) begin
        r_word <= '0;
        r_k    <= '0;
      end
    end
  end

  // A completed word is lost only when the FIFO is full and nothing leaves.
  always_comb begin
    w_pop  = !w_empty && m_axis_tready;
    w_drop = r_push && w_full && !w_pop;
  end

  // Sticky overflow and saturating drop counter; a same-cycle drop wins over clear.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (ovf_clear) begin
      r_overflow   <= w_drop;
      r_drop_count <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  jesd_fwft_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .i_push  (r_push && !w_drop),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (m_axis_tdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fill_level)
  );

  assign m_axis_tvalid = !w_empty;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_jesd_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jesd_sample_packer
// Description : Self-checking bench for jesd_sample_packer (default params,
//               plus a pass-through instance) with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd_sample_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  data;
  logic         valid;
  logic         restart;
  logic         tready;
  logic         ovf_clear;

  logic [127:0] tdata, ns_tdata;
  logic         tvalid, ns_tvalid;
  logic         ovf, ns_ovf;
  logic [15:0]  cnt, ns_cnt;
  logic [3:0]   fill, ns_fill;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jesd_sample_packer dut (
    .aclk(clk), .areset(rst), .s_axis_tdata(data), .s_axis_tvalid(valid),
    .sync_restart(restart), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .ovf_clear(ovf_clear), .overflow(ovf),
    .drop_count(cnt), .fill_level(fill)
  );

  jesd_sample_packer #(.SWAP_EN(1'b0)) dut_ns (
    .aclk(clk), .areset(rst), .s_axis_tdata(data), .s_axis_tvalid(valid),
    .sync_restart(restart), .m_axis_tdata(ns_tdata), .m_axis_tvalid(ns_tvalid),
    .m_axis_tready(tready), .ovf_clear(ovf_clear), .overflow(ns_ovf),
    .drop_count(ns_cnt), .fill_level(ns_fill)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Swap bytes inside each 16-bit sample.
  function automatic logic [31:0] mswap(input logic [31:0] d);
    logic [31:0] r;
    for (int s = 0; s < 2; s++) r[s*16 +: 16] = {d[s*16 +: 8], d[s*16+8 +: 8]};
    return r;
  endfunction

  // Model state: FIFO contents, partial beats, word waiting to enter the FIFO.
  logic [127:0] mq[$];
  logic [31:0]  mbeats[$];
  bit           mpend;
  logic [127:0] mpend_w;
  bit           movf;
  int           mcnt;

  always @(posedge clk) begin : model
    bit pop;
    bit drop;
    if (rst) begin
      mq.delete(); mbeats.delete();
      mpend = 0; movf = 0; mcnt = 0;
    end else begin
      pop  = (mq.size() != 0) && tready;
      drop = mpend && (mq.size() == 8) && !pop;
      if (pop) void'(mq.pop_front());
      if (mpend && !drop) mq.push_back(mpend_w);
      if (ovf_clear) begin
        movf = drop;
        mcnt = drop ? 1 : 0;
      end else if (drop) begin
        movf = 1;
        if (mcnt < 65535) mcnt++;
      end
      mpend = 0;
      if (restart) mbeats.delete();
      if (valid) begin
        mbeats.push_back(mswap(data));
        if (mbeats.size() == 4) begin
          mpend_w = {mbeats[3], mbeats[2], mbeats[1], mbeats[0]};
          mpend   = 1;
          mbeats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    check("tvalid", tvalid, mq.size() != 0);
    check("fill_level", fill, mq.size());
    check("overflow", ovf, movf);
    check("drop_count", cnt, mcnt);
    if (mq.size() != 0) check("tdata", tdata, mq[0]);
  end

  task automatic send(input logic [31:0] d);
    valid = 1'b1;
    data  = d;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1; data = '0; valid = 1'b0; restart = 1'b0; tready = 1'b0; ovf_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tvalid", tvalid, 0);
    check("reset_tdata", tdata, 0);
    check("reset_fill", fill, 0);
    check("reset_ovf", {ovf, cnt}, 0);

    // Basic packing with and without swap
    tready = 1'b1;
    send(32'h0102_0304); send(32'h0506_0708); send(32'h090A_0B0C); send(32'h0D0E_0F10);
    @(negedge clk);
    check("t1_latency_not_yet", tvalid, 0);
    @(negedge clk);
    check("t1_tvalid", tvalid, 1);
    check("t1_word", tdata, 128'h0E0D100F_0A090C0B_06050807_02010403);
    check("t2_word_noswap", ns_tdata, 128'h0D0E0F10_090A0B0C_05060708_01020304);
    repeat (3) @(negedge clk);
    check("t1_drained", fill, 0);

    // Fill with backpressure, ninth word dropped
    tready = 1'b0;
    for (int w = 0; w < 9; w++)
      for (int b = 0; b < 4; b++) send(32'h1000_0000 + 32'(w * 16 + b));
    repeat (3) @(negedge clk);
    check("t3_fill", fill, 8);
    check("t3_ovf", ovf, 1);
    check("t3_cnt", cnt, 1);

    // Tenth word completes while a pop happens
    for (int b = 0; b < 4; b++) send(32'h2000_0000 + 32'(b));
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    @(negedge clk);
    check("t4_cnt", cnt, 1);
    check("t4_fill", fill, 8);
    tready = 1'b1;
    repeat (12) @(negedge clk);
    check("t3_drain_empty", fill, 0);

    // Realignment
    send(32'h1111_1111); send(32'h2222_2222);
    restart = 1'b1;
    send(32'hAAAA_BBBB);
    restart = 1'b0;
    send(32'h1122_3344); send(32'h5566_7788); send(32'h99AA_BBCC);
    t = 0;
    while (!tvalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t5_tvalid", tvalid, 1);
    check("t5_word", tdata, 128'hAA99CCBB_66558877_22114433_AAAABBBB);
    repeat (3) @(negedge clk);

    // Clear, then clear coinciding with a drop
    tready = 1'b0;
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    @(negedge clk);
    check("t6_cleared", {ovf, cnt}, 0);
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++) send(32'h3000_0000 + 32'(w * 16 + b));
    for (int b = 0; b < 4; b++) send(32'h4000_0000 + 32'(b));
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    @(negedge clk);
    check("t6_ovf", ovf, 1);
    check("t6_cnt", cnt, 1);
    check("t6_fill", fill, 8);

    // Reset with buffered words and a partial word
    send(32'h5555_0000); send(32'h5555_0001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_tvalid", tvalid, 0);
    check("t6_rst_fill", fill, 0);
    check("t6_rst_ovf", {ovf, cnt}, 0);
    tready = 1'b1;
    send(32'h6000_0001); send(32'h6000_0002); send(32'h6000_0003); send(32'h6000_0004);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
